// File: rtl/feature_bank_mem.sv
// rtl/feature_bank_mem.sv - multi-bank feature/weight buffer with stream preload and bulk clear
// Optional macro RDW_FORWARD_EN: same-cycle port A read / port B write returns the new word.
module feature_bank_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int NUM_BANKS  = 8,
    localparam int ADDR_WIDTH = $clog2(NUM_BANKS * DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csen,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic                  rdena,
    output logic [DATA_WIDTH-1:0] data_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  wrenb,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  load_start,
    input  logic                  load_clear,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic                  load_done
);

    localparam int TOTAL = NUM_BANKS * DEPTH;
    localparam logic [ADDR_WIDTH:0]   TOTAL_X = (ADDR_WIDTH + 1)'(TOTAL);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(TOTAL - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CLEAR, S_DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] load_ptr, ptr_nx;
    logic                  eng_we;
    logic [DATA_WIDTH-1:0] eng_wdata;

    // Banks are contiguous DEPTH-word slices of one flat array, so the bank
    // index is simply the upper address bits.
    logic [DATA_WIDTH-1:0] mem [TOTAL];

    logic port_en, rd_q, wr_q;

    assign port_en = csen & ~load_busy;
    assign rd_q    = rdena & port_en & ({1'b0, addr_a} < TOTAL_X);
    assign wr_q    = wrenb & port_en & ({1'b0, addr_b} < TOTAL_X);

    // Engine writes only while busy, which already locks port B out.
    always_ff @(posedge clk) begin
        if (eng_we) begin
            mem[load_ptr] <= eng_wdata;
        end else if (wr_q) begin
            mem[addr_b] <= data_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_a <= '0;
        end else if (rd_q) begin
`ifdef RDW_FORWARD_EN
            if (wr_q && (addr_b == addr_a)) begin
                data_a <= data_b;
            end else begin
                data_a <= mem[addr_a];
            end
`else
            data_a <= mem[addr_a];
`endif
        end else begin
            data_a <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            load_ptr <= '0;
        end else begin
            state    <= state_nx;
            load_ptr <= ptr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ptr_nx     = load_ptr;
        load_ready = 1'b0;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        eng_we     = 1'b0;
        eng_wdata  = '0;
        case (state)
            S_IDLE: begin
                ptr_nx = '0;
                if (load_start) begin
                    state_nx = load_clear ? S_CLEAR : S_LOAD;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                load_busy  = 1'b1;
                if (load_valid) begin
                    eng_we    = 1'b1;
                    eng_wdata = load_data;
                    if (load_ptr == LAST) begin
                        state_nx = S_DONE;
                    end else begin
                        ptr_nx = load_ptr + ADDR_WIDTH'(1);
                    end
                end
            end
            S_CLEAR: begin
                load_busy = 1'b1;
                eng_we    = 1'b1;
                if (load_ptr == LAST) begin
                    state_nx = S_DONE;
                end else begin
                    ptr_nx = load_ptr + ADDR_WIDTH'(1);
                end
            end
            S_DONE: begin
                load_busy = 1'b1;
                load_done = 1'b1;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
